// File: rtl/csr_exec_unit_if.sv
// Bundles the decode-side request, trap/return controls and CSR file hookups of csr_exec_unit.
// The slave modport is the sequencer; the master modport is whatever surrounds it.
interface csr_exec_unit_if;
    logic        VALID_IN;
    logic [2:0]  FUNCT3;
    logic [11:0] CSR_ADDR;
    logic [4:0]  RS1_FIELD;
    logic [63:0] RS1_DATA;
    logic [4:0]  RD_IN;
    logic        EXC_REQ;
    logic [63:0] EXC_CAUSE;
    logic [63:0] EXC_PC;
    logic        MRET;
    logic [1:0]  PRIVILEGE;
    logic [63:0] CSR_RDATA;
    logic [63:0] MTVEC_IN;
    logic        READY;
    logic [11:0] CSR_SR;
    logic [11:0] CSR_DR;
    logic [63:0] CSR_WDATA;
    logic        CSR_LD;
    logic        RD_WE;
    logic [4:0]  RD_ADDR;
    logic [63:0] RD_WDATA;
    logic        ILLEGAL;
    logic        REDIRECT;
    logic [63:0] REDIRECT_PC;

    modport master (
        output VALID_IN, FUNCT3, CSR_ADDR, RS1_FIELD, RS1_DATA, RD_IN,
        output EXC_REQ, EXC_CAUSE, EXC_PC, MRET, PRIVILEGE, CSR_RDATA, MTVEC_IN,
        input  READY, CSR_SR, CSR_DR, CSR_WDATA, CSR_LD, RD_WE, RD_ADDR,
        input  RD_WDATA, ILLEGAL, REDIRECT, REDIRECT_PC
    );

    modport slave (
        input  VALID_IN, FUNCT3, CSR_ADDR, RS1_FIELD, RS1_DATA, RD_IN,
        input  EXC_REQ, EXC_CAUSE, EXC_PC, MRET, PRIVILEGE, CSR_RDATA, MTVEC_IN,
        output READY, CSR_SR, CSR_DR, CSR_WDATA, CSR_LD, RD_WE, RD_ADDR,
        output RD_WDATA, ILLEGAL, REDIRECT, REDIRECT_PC
    );
endinterface

// File: rtl/csr_exec_unit.sv
// Zicsr read-modify-write, machine trap entry and MRET sequencer driving the CSR file.
// Control outputs are registered; write/return data follow the file's combinational read.
module csr_exec_unit #(
    parameter logic [11:0] MEPC_ADDR    = 12'h341,
    parameter logic [11:0] MCAUSE_ADDR  = 12'h342,
    parameter logic [11:0] MSTATUS_ADDR = 12'h300
) (
    input  logic           CLK,
    input  logic           RST_N,
    csr_exec_unit_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EXEC    = 3'd1,
        S_T_EPC   = 3'd2,
        S_T_CAUSE = 3'd3,
        S_T_STAT  = 3'd4,
        S_M_STAT  = 3'd5,
        S_M_EPC   = 3'd6
    } state_t;

    state_t      r_state;
    logic [2:0]  r_funct3;
    logic [4:0]  r_rs1_field;
    logic [63:0] r_rs1_data;
    logic [63:0] r_cause;
    logic [63:0] r_pc;
    logic [1:0]  r_priv;

    logic        r_ready;
    logic [11:0] r_sr;
    logic [11:0] r_dr;
    logic        r_ld;
    logic        r_rd_we;
    logic [4:0]  r_rd_addr;
    logic        r_illegal;
    logic        r_redirect;

    logic        w_acc_write;
    logic        w_acc_ro;
    logic [63:0] w_src;
    logic [63:0] w_exec_new;
    logic [63:0] w_tvec_base;
    logic [63:0] w_trap_pc;
    logic [63:0] w_wdata;
    logic [63:0] w_rpc;

    function automatic logic [63:0] f_trap_mstatus(input logic [63:0] old, input logic [1:0] priv);
        logic [63:0] v;
        v        = old;
        v[7]     = old[3];
        v[3]     = 1'b0;
        v[12:11] = priv;
        return v;
    endfunction

    function automatic logic [63:0] f_mret_mstatus(input logic [63:0] old);
        logic [63:0] v;
        v        = old;
        v[3]     = old[7];
        v[7]     = 1'b1;
        v[12:11] = 2'b00;
        return v;
    endfunction

    // Set/clear forms with a zero rs1 field leave the CSR untouched; only writes can fault.
    assign w_acc_write = (bus.FUNCT3[1:0] == 2'b01) || (bus.RS1_FIELD != 5'd0);
    assign w_acc_ro    = (bus.CSR_ADDR[11:10] == 2'b11);

    // Read-modify-write result for the latched Zicsr operation
    always_comb begin
        w_src = r_funct3[2] ? {59'd0, r_rs1_field} : r_rs1_data;
        case (r_funct3[1:0])
            2'b01:   w_exec_new = w_src;
            2'b10:   w_exec_new = bus.CSR_RDATA | w_src;
            2'b11:   w_exec_new = bus.CSR_RDATA & ~w_src;
            default: w_exec_new = bus.CSR_RDATA;
        endcase
    end

    // Trap target: vectored mode only offsets interrupts, not synchronous exceptions
    always_comb begin
        w_tvec_base = {bus.MTVEC_IN[63:2], 2'b00};
        if ((bus.MTVEC_IN[1:0] == 2'b01) && r_cause[63]) begin
            w_trap_pc = w_tvec_base + {r_cause[61:0], 2'b00};
        end else begin
            w_trap_pc = w_tvec_base;
        end
    end

    // Per-state write data and redirect target
    always_comb begin
        w_wdata = 64'd0;
        w_rpc   = 64'd0;
        case (r_state)
            S_EXEC:    w_wdata = r_ld ? w_exec_new : 64'd0;
            S_T_EPC:   w_wdata = r_pc;
            S_T_CAUSE: w_wdata = r_cause;
            S_T_STAT: begin
                w_wdata = f_trap_mstatus(bus.CSR_RDATA, r_priv);
                w_rpc   = w_trap_pc;
            end
            S_M_STAT:  w_wdata = f_mret_mstatus(bus.CSR_RDATA);
            S_M_EPC:   w_rpc   = {bus.CSR_RDATA[63:2], 2'b00};
            default: begin
                w_wdata = 64'd0;
                w_rpc   = 64'd0;
            end
        endcase
    end

    // Sequencer: state, latched operands and the registered control outputs of the next state
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= S_IDLE;
            r_funct3    <= 3'd0;
            r_rs1_field <= 5'd0;
            r_rs1_data  <= 64'd0;
            r_cause     <= 64'd0;
            r_pc        <= 64'd0;
            r_priv      <= 2'd0;
            r_ready     <= 1'b1;
            r_sr        <= 12'd0;
            r_dr        <= 12'd0;
            r_ld        <= 1'b0;
            r_rd_we     <= 1'b0;
            r_rd_addr   <= 5'd0;
            r_illegal   <= 1'b0;
            r_redirect  <= 1'b0;
        end else begin
            r_ready    <= 1'b0;
            r_sr       <= 12'd0;
            r_dr       <= 12'd0;
            r_ld       <= 1'b0;
            r_rd_we    <= 1'b0;
            r_rd_addr  <= 5'd0;
            r_illegal  <= 1'b0;
            r_redirect <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.EXC_REQ) begin
                        r_pc    <= bus.EXC_PC;
                        r_cause <= bus.EXC_CAUSE;
                        r_priv  <= bus.PRIVILEGE;
                        r_dr    <= MEPC_ADDR;
                        r_ld    <= 1'b1;
                        r_state <= S_T_EPC;
                    end else if (bus.MRET) begin
                        r_sr    <= MSTATUS_ADDR;
                        r_dr    <= MSTATUS_ADDR;
                        r_ld    <= 1'b1;
                        r_state <= S_M_STAT;
                    end else if (bus.VALID_IN) begin
                        if (bus.FUNCT3[1:0] == 2'b00) begin
                            r_illegal <= 1'b1;
                            r_ready   <= 1'b1;
                            r_state   <= S_IDLE;
                        end else begin
                            r_funct3    <= bus.FUNCT3;
                            r_rs1_field <= bus.RS1_FIELD;
                            r_rs1_data  <= bus.RS1_DATA;
                            r_sr        <= bus.CSR_ADDR;
                            r_dr        <= bus.CSR_ADDR;
                            if (w_acc_write && w_acc_ro) begin
                                r_illegal <= 1'b1;
                            end else begin
                                r_ld      <= w_acc_write;
                                r_rd_we   <= (bus.RD_IN != 5'd0);
                                r_rd_addr <= bus.RD_IN;
                            end
                            r_state <= S_EXEC;
                        end
                    end else begin
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                S_EXEC: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                S_T_EPC: begin
                    r_dr    <= MCAUSE_ADDR;
                    r_ld    <= 1'b1;
                    r_state <= S_T_CAUSE;
                end
                S_T_CAUSE: begin
                    r_sr       <= MSTATUS_ADDR;
                    r_dr       <= MSTATUS_ADDR;
                    r_ld       <= 1'b1;
                    r_redirect <= 1'b1;
                    r_state    <= S_T_STAT;
                end
                S_M_STAT: begin
                    r_sr       <= MEPC_ADDR;
                    r_redirect <= 1'b1;
                    r_state    <= S_M_EPC;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.READY       = r_ready;
    assign bus.CSR_SR      = r_sr;
    assign bus.CSR_DR      = r_dr;
    assign bus.CSR_WDATA   = w_wdata;
    assign bus.CSR_LD      = r_ld;
    assign bus.RD_WE       = r_rd_we;
    assign bus.RD_ADDR     = r_rd_addr;
    assign bus.RD_WDATA    = r_rd_we ? bus.CSR_RDATA : 64'd0;
    assign bus.ILLEGAL     = r_illegal;
    assign bus.REDIRECT    = r_redirect;
    assign bus.REDIRECT_PC = w_rpc;

endmodule

// File: tb/tb_csr_exec_unit.sv
// Self-checking bench for csr_exec_unit: a CSR file model answers the DUT, and a
// transaction-level reference predicts every output cycle from the architectural rules.
module tb_csr_exec_unit;

    logic CLK;
    logic RST_N;

    csr_exec_unit_if bus ();

    csr_exec_unit dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        ready;
        logic        chk_sr;
        logic [11:0] sr;
        logic [11:0] dr;
        logic [63:0] wdata;
        logic        ld;
        logic        rd_we;
        logic [4:0]  rd_addr;
        logic [63:0] rd_wdata;
        logic        illegal;
        logic        redirect;
        logic [63:0] rpc;
    } rec_t;

    int   n_chk  = 0;
    int   n_pass = 0;
    rec_t exp_q[$];
    rec_t cur;

    logic [63:0] file_mem [0:4095];
    logic [63:0] ref_mem  [0:4095];
    logic        pre_en   = 1'b0;
    logic        init_en  = 1'b0;
    logic [11:0] pre_addr = 12'd0;
    logic [63:0] pre_val  = 64'd0;

    function automatic logic [63:0] init_val(input int a);
        logic [11:0] x;
        x = a[11:0];
        return {x, 4'h5, x, 4'hA, x, 4'h3, x, 4'h0};
    endfunction

    // CSR file stand-in: combinational read, write on the rising edge
    assign bus.CSR_RDATA = file_mem[bus.CSR_SR];
    always @(posedge CLK) begin
        if (init_en) for (int i = 0; i < 4096; i++) file_mem[i] <= init_val(i);
        if (pre_en) file_mem[pre_addr] <= pre_val;
        if (bus.CSR_LD) file_mem[bus.CSR_DR] <= bus.CSR_WDATA;
    end

    function automatic rec_t blank_rec();
        rec_t r;
        r.ready = 1'b0; r.chk_sr = 1'b0; r.sr = 12'd0; r.dr = 12'd0; r.wdata = 64'd0;
        r.ld = 1'b0; r.rd_we = 1'b0; r.rd_addr = 5'd0; r.rd_wdata = 64'd0;
        r.illegal = 1'b0; r.redirect = 1'b0; r.rpc = 64'd0;
        return r;
    endfunction

    function automatic rec_t idle_rec();
        rec_t r;
        r = blank_rec();
        r.ready  = 1'b1;
        r.chk_sr = 1'b1;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic compare(input rec_t r);
        chk("ready",    64'(bus.READY),    64'(r.ready));
        chk("csr_ld",   64'(bus.CSR_LD),   64'(r.ld));
        chk("rd_we",    64'(bus.RD_WE),    64'(r.rd_we));
        chk("illegal",  64'(bus.ILLEGAL),  64'(r.illegal));
        chk("redirect", 64'(bus.REDIRECT), 64'(r.redirect));
        if (r.chk_sr) chk("csr_sr", 64'(bus.CSR_SR), 64'(r.sr));
        if (r.ld || r.ready) begin
            chk("csr_dr",    64'(bus.CSR_DR), 64'(r.dr));
            chk("csr_wdata", bus.CSR_WDATA,   r.wdata);
        end
        if (r.rd_we) begin
            chk("rd_addr",  64'(bus.RD_ADDR), 64'(r.rd_addr));
            chk("rd_wdata", bus.RD_WDATA,     r.rd_wdata);
        end
        if (r.redirect) chk("redirect_pc", bus.REDIRECT_PC, r.rpc);
    endtask

    task automatic idle_inputs();
        bus.VALID_IN = 1'b0; bus.EXC_REQ = 1'b0; bus.MRET = 1'b0;
        bus.FUNCT3 = 3'd0; bus.CSR_ADDR = 12'd0; bus.RS1_FIELD = 5'd0;
        bus.RS1_DATA = 64'd0; bus.RD_IN = 5'd0; bus.EXC_CAUSE = 64'd0;
        bus.EXC_PC = 64'd0; bus.PRIVILEGE = 2'd0;
    endtask

    // Architectural reference for one accepted request; appends its output cycles
    task automatic model_accept(input logic exc, input logic mret, input logic valid,
                                input logic [2:0] f3, input logic [11:0] addr,
                                input logic [4:0] rs1f, input logic [63:0] rs1d,
                                input logic [4:0] rd, input logic [63:0] cause,
                                input logic [63:0] pc, input logic [1:0] priv);
        rec_t r;
        logic [63:0] old, src, nv, tgt;
        logic wr, ro;
        if (exc) begin
            ref_mem[12'h341] = pc;
            ref_mem[12'h342] = cause;
            old = ref_mem[12'h300];
            nv  = (old & ~64'h1888) | (64'(old[3]) << 7) | (64'(priv) << 11);
            ref_mem[12'h300] = nv;
            tgt = bus.MTVEC_IN & ~64'd3;
            if (bus.MTVEC_IN[1:0] == 2'b01 && cause[63]) tgt = tgt + (cause & 64'h7FFF_FFFF_FFFF_FFFF) * 64'd4;
            r = blank_rec(); r.ld = 1'b1; r.dr = 12'h341; r.wdata = pc;    exp_q.push_back(r);
            r = blank_rec(); r.ld = 1'b1; r.dr = 12'h342; r.wdata = cause; exp_q.push_back(r);
            r = blank_rec(); r.ld = 1'b1; r.chk_sr = 1'b1; r.sr = 12'h300; r.dr = 12'h300;
            r.wdata = nv; r.redirect = 1'b1; r.rpc = tgt; exp_q.push_back(r);
        end else if (mret) begin
            old = ref_mem[12'h300];
            nv  = (old & ~64'h1888) | (64'(old[7]) << 3) | 64'h80;
            ref_mem[12'h300] = nv;
            r = blank_rec(); r.ld = 1'b1; r.chk_sr = 1'b1; r.sr = 12'h300; r.dr = 12'h300;
            r.wdata = nv; exp_q.push_back(r);
            r = blank_rec(); r.chk_sr = 1'b1; r.sr = 12'h341; r.redirect = 1'b1;
            r.rpc = ref_mem[12'h341] & ~64'd3; exp_q.push_back(r);
        end else if (valid) begin
            if (f3 == 3'd0 || f3 == 3'd4) begin
                r = idle_rec(); r.illegal = 1'b1; exp_q.push_back(r);
            end else begin
                old = ref_mem[addr];
                src = f3[2] ? 64'(rs1f) : rs1d;
                wr  = (f3 == 3'd1 || f3 == 3'd5) || (rs1f != 5'd0);
                ro  = (addr >= 12'hC00);
                if (f3 == 3'd1 || f3 == 3'd5)      nv = src;
                else if (f3 == 3'd2 || f3 == 3'd6) nv = old | src;
                else                               nv = old & ~src;
                r = blank_rec(); r.chk_sr = 1'b1; r.sr = addr;
                if (wr && ro) begin
                    r.illegal = 1'b1;
                end else begin
                    r.ld = wr; r.dr = addr; r.wdata = nv;
                    r.rd_we = (rd != 5'd0); r.rd_addr = rd; r.rd_wdata = old;
                    if (wr) ref_mem[addr] = nv;
                end
                exp_q.push_back(r);
            end
        end
    endtask

    task automatic offer(input logic exc, input logic mret, input logic valid,
                         input logic [2:0] f3, input logic [11:0] addr,
                         input logic [4:0] rs1f, input logic [63:0] rs1d,
                         input logic [4:0] rd, input logic [63:0] cause,
                         input logic [63:0] pc, input logic [1:0] priv);
        bus.EXC_REQ = exc; bus.MRET = mret; bus.VALID_IN = valid;
        bus.FUNCT3 = f3; bus.CSR_ADDR = addr; bus.RS1_FIELD = rs1f; bus.RS1_DATA = rs1d;
        bus.RD_IN = rd; bus.EXC_CAUSE = cause; bus.EXC_PC = pc; bus.PRIVILEGE = priv;
        if (cur.ready) model_accept(exc, mret, valid, f3, addr, rs1f, rs1d, rd, cause, pc, priv);
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
        pre_en = 1'b0;
        if (exp_q.size() > 0) cur = exp_q.pop_front();
        else cur = idle_rec();
        compare(cur);
    endtask

    task automatic set_csr(input logic [11:0] a, input logic [63:0] v);
        pre_en = 1'b1; pre_addr = a; pre_val = v;
        ref_mem[a] = v;
        tick();
    endtask

    function automatic logic [11:0] pick_addr();
        case ($urandom_range(0, 7))
            0:       return 12'h340;
            1:       return 12'h300;
            2:       return 12'h341;
            3:       return 12'h342;
            4:       return 12'hC00;
            5:       return 12'hF11;
            6:       return 12'h305;
            default: return 12'($urandom_range(0, 4095));
        endcase
    endfunction

    initial begin
        logic [63:0] saved, v;
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(i);
        cur = idle_rec();
        idle_inputs();
        bus.MTVEC_IN = 64'd0;
        RST_N = 1'b1;
        #1 RST_N = 1'b0;
        init_en = 1'b1;
        #1;
        chk("reset_ready",    64'(bus.READY),    64'd1);
        chk("reset_ld",       64'(bus.CSR_LD),   64'd0);
        chk("reset_sr",       64'(bus.CSR_SR),   64'd0);
        chk("reset_redirect", 64'(bus.REDIRECT), 64'd0);
        @(posedge CLK);
        @(negedge CLK);
        init_en = 1'b0;
        RST_N = 1'b1;

        // CSRRS x7, 0x340, x5
        set_csr(12'h340, 64'h00F0);
        offer(1'b0, 1'b0, 1'b1, 3'd2, 12'h340, 5'd5, 64'h0F00, 5'd7, 64'd0, 64'd0, 2'd0);
        tick(); idle_inputs();
        chk("csrrs_ready_low", 64'(bus.READY),    64'd0);
        chk("csrrs_wdata",     bus.CSR_WDATA,     64'h0FF0);
        chk("csrrs_ld",        64'(bus.CSR_LD),   64'd1);
        chk("csrrs_rd_addr",   64'(bus.RD_ADDR),  64'd7);
        chk("csrrs_rd_wdata",  bus.RD_WDATA,      64'h00F0);
        tick();
        chk("csrrs_ready_back", 64'(bus.READY), 64'd1);
        chk("csrrs_commit",     file_mem[12'h340], 64'h0FF0);

        // CSRRCI with zimm=0: read only
        offer(1'b0, 1'b0, 1'b1, 3'd7, 12'h300, 5'd0, 64'd0, 5'd3, 64'd0, 64'd0, 2'd0);
        tick(); idle_inputs();
        chk("csrrci0_ld",    64'(bus.CSR_LD), 64'd0);
        chk("csrrci0_rd_we", 64'(bus.RD_WE),  64'd1);
        tick();

        // CSRRW to read-only CSR
        offer(1'b0, 1'b0, 1'b1, 3'd1, 12'hC00, 5'd1, 64'h1234, 5'd4, 64'd0, 64'd0, 2'd0);
        tick(); idle_inputs();
        chk("ro_illegal", 64'(bus.ILLEGAL), 64'd1);
        chk("ro_ld",      64'(bus.CSR_LD),  64'd0);
        chk("ro_rd_we",   64'(bus.RD_WE),   64'd0);
        tick();

        // Trap with all three requests raised: trap wins
        set_csr(12'h300, 64'h8);
        bus.MTVEC_IN = 64'h8000_0000;
        offer(1'b1, 1'b1, 1'b1, 3'd1, 12'h340, 5'd9, 64'hDEAD, 5'd1, 64'd2, 64'h8000_0100, 2'd3);
        tick(); idle_inputs();
        chk("trap_epc_dr",    64'(bus.CSR_DR), 64'h341);
        chk("trap_epc_wdata", bus.CSR_WDATA,   64'h8000_0100);
        tick();
        chk("trap_cause_wdata", bus.CSR_WDATA, 64'd2);
        tick();
        chk("trap_stat_wdata", bus.CSR_WDATA,   64'h1880);
        chk("trap_redirect",   64'(bus.REDIRECT), 64'd1);
        chk("trap_pc",         bus.REDIRECT_PC, 64'h8000_0000);
        tick();
        chk("prio_no_csr_write", file_mem[12'h340], 64'h0FF0);

        // Vectored interrupt
        bus.MTVEC_IN = 64'h8000_0001;
        offer(1'b1, 1'b0, 1'b0, 3'd0, 12'd0, 5'd0, 64'd0, 5'd0, 64'h8000_0000_0000_0007, 64'h1000, 2'd0);
        tick(); idle_inputs();
        tick();
        tick();
        chk("vector_pc", bus.REDIRECT_PC, 64'h8000_001C);
        tick();

        // MRET
        set_csr(12'h300, 64'h1880);
        set_csr(12'h341, 64'h8000_0102);
        offer(1'b0, 1'b1, 1'b0, 3'd0, 12'd0, 5'd0, 64'd0, 5'd0, 64'd0, 64'd0, 2'd0);
        tick(); idle_inputs();
        chk("mret_stat", bus.CSR_WDATA, 64'h0088);
        tick();
        chk("mret_redirect", 64'(bus.REDIRECT), 64'd1);
        chk("mret_pc",       bus.REDIRECT_PC,   64'h8000_0100);
        tick();

        // Reserved funct3
        offer(1'b0, 1'b0, 1'b1, 3'd4, 12'h340, 5'd2, 64'd0, 5'd2, 64'd0, 64'd0, 2'd0);
        tick(); idle_inputs();
        chk("f3_illegal", 64'(bus.ILLEGAL), 64'd1);
        tick();

        // Asynchronous reset in the middle of EXEC
        saved = ref_mem[12'h340];
        offer(1'b0, 1'b0, 1'b1, 3'd2, 12'h340, 5'd5, 64'hF000, 5'd7, 64'd0, 64'd0, 2'd0);
        tick(); idle_inputs();
        #2 RST_N = 1'b0;
        #1;
        chk("arst_ready",    64'(bus.READY),    64'd1);
        chk("arst_ld",       64'(bus.CSR_LD),   64'd0);
        chk("arst_rd_we",    64'(bus.RD_WE),    64'd0);
        chk("arst_sr",       64'(bus.CSR_SR),   64'd0);
        chk("arst_dr",       64'(bus.CSR_DR),   64'd0);
        chk("arst_wdata",    bus.CSR_WDATA,     64'd0);
        chk("arst_rd_addr",  64'(bus.RD_ADDR),  64'd0);
        chk("arst_rd_wdata", bus.RD_WDATA,      64'd0);
        chk("arst_illegal",  64'(bus.ILLEGAL),  64'd0);
        chk("arst_redirect", 64'(bus.REDIRECT), 64'd0);
        chk("arst_rpc",      bus.REDIRECT_PC,   64'd0);
        exp_q.delete();
        ref_mem[12'h340] = saved;
        @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        cur = idle_rec();

        // Randomized traffic, including requests offered while busy
        for (int i = 0; i < 4000; i++) begin
            if (cur.ready) begin
                v = {$urandom, $urandom};
                v[1:0] = 2'($urandom_range(0, 1));
                bus.MTVEC_IN = v;
            end
            v = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) v[63] = 1'b1;
            offer(($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)), pick_addr(),
                  ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                  {$urandom, $urandom},
                  ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                  v, {$urandom, $urandom}, 2'($urandom_range(0, 3)));
            tick();
        end
        idle_inputs();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/csr_exec_unit.md
Name: csr_exec_unit

Overview:
- Sequencer directly upstream of the CSR register file. It is the sole driver of the file's SR, DR, DATA and LD_REG inputs.
- Executes Zicsr instructions (CSRRW/S/C and the immediate variants) as a read-modify-write.
- Performs machine-mode trap entry (writes mepc, mcause, mstatus, then redirects to MTVEC) and MRET return.
- Sits between decode/execute and the CSR file; returns the old CSR value for the integer writeback port.

Parameters:
- MEPC_ADDR, 12'h341, mepc CSR address
- MCAUSE_ADDR, 12'h342, mcause CSR address
- MSTATUS_ADDR, 12'h300, mstatus CSR address

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- VALID_IN  in  1  CSR instruction offered; sampled only when READY=1
- FUNCT3  in  3  Zicsr funct3
- CSR_ADDR  in  12  target CSR
- RS1_FIELD  in  5  rs1 index, or zimm for the immediate variants
- RS1_DATA  in  64  rs1 value
- RD_IN  in  5  destination register
- EXC_REQ  in  1  exception request; sampled only when READY=1
- EXC_CAUSE  in  64  mcause value to write
- EXC_PC  in  64  faulting PC, written to mepc
- MRET  in  1  MRET request; sampled only when READY=1
- PRIVILEGE  in  2  current privilege level, saved into MPP
- CSR_RDATA  in  64  CSR file OUT (combinational read of CSR_SR)
- MTVEC_IN  in  64  CSR file MTVEC
- READY  out  1  high in IDLE
- CSR_SR  out  12  CSR file read select
- CSR_DR  out  12  CSR file write select
- CSR_WDATA  out  64  CSR file write data
- CSR_LD  out  1  CSR file write enable (LD_REG)
- RD_WE  out  1  integer register write strobe
- RD_ADDR  out  5  integer destination register
- RD_WDATA  out  64  old CSR value
- ILLEGAL  out  1  one-cycle illegal-instruction pulse
- REDIRECT  out  1  one-cycle PC redirect strobe
- REDIRECT_PC  out  64  redirect target

Behaviour:
- Reset (asynchronous, any state): state=IDLE, latched operands cleared. All outputs 0 except READY=1.
- States: IDLE, EXEC, T_EPC, T_CAUSE, T_STAT, M_STAT, M_EPC.
- IDLE accepts at most one request per cycle. Priority is EXC_REQ > MRET > VALID_IN. The winning request's operands are latched on the rising edge; lower-priority requests are dropped and upstream re-presents them.
- Transitions from IDLE:
  - EXC_REQ -> T_EPC.
  - MRET -> M_STAT.
  - VALID_IN with FUNCT3 of 0 or 4 -> stay in IDLE, ILLEGAL=1 next cycle.
  - Otherwise -> EXEC.
- EXEC (1 cycle):
  - CSR_SR=CSR_DR=addr; old=CSR_RDATA.
  - Operand src = RS1_DATA when FUNCT3[2]=0, else zero-extended RS1_FIELD.
  - New value: RW -> src; RS -> old|src; RC -> old&~src.
  - Write suppressed for RS/RC/RSI/RCI when RS1_FIELD=0. RW/RWI always write.
  - Write to a read-only CSR (addr[11:10]=2'b11) with the write not suppressed: ILLEGAL=1, CSR_LD=0, RD_WE=0.
  - Otherwise: CSR_LD=write, RD_WE=(RD_IN!=0), RD_ADDR=RD_IN, RD_WDATA=old.
  - -> IDLE.
- Instruction latency: accept edge, then EXEC for one cycle (the file commits on the closing edge), then READY again. Throughput is one op per 2 cycles.
- T_EPC: CSR_DR=MEPC_ADDR, CSR_WDATA=EXC_PC, CSR_LD=1 -> T_CAUSE.
- T_CAUSE: CSR_DR=MCAUSE_ADDR, CSR_WDATA=EXC_CAUSE, CSR_LD=1 -> T_STAT.
- T_STAT:
  - CSR_SR=CSR_DR=MSTATUS_ADDR, CSR_LD=1.
  - Write old with: bit7(MPIE) = old bit3, bit3(MIE)=0, bits12:11(MPP) = PRIVILEGE latched at accept.
  - REDIRECT=1 in the same cycle.
  - REDIRECT_PC:
    - MTVEC_IN[1:0]=1 and cause bit63=1 -> {MTVEC_IN[63:2],2'b00} + 4*cause[62:0], truncated to 64 bits.
    - Otherwise -> {MTVEC_IN[63:2],2'b00}.
  - -> IDLE.
- M_STAT: CSR_SR=CSR_DR=MSTATUS_ADDR, CSR_LD=1; write MIE=old MPIE, MPIE=1, MPP=2'b00 -> M_EPC.
- M_EPC: CSR_SR=MEPC_ADDR, CSR_LD=0, REDIRECT=1, REDIRECT_PC={CSR_RDATA[63:2],2'b00} -> IDLE.
- When not asserted, CSR_LD, RD_WE, ILLEGAL and REDIRECT are 0, and SR/DR/WDATA are 0.
- Reset mid-sequence abandons it; partial CSR writes already committed remain. A bench must not expect rollback.

Test Plan:
- Reset: RST_N low asynchronously mid-EXEC -> all outputs 0 and READY=1 immediately, without a clock edge.
- CSRRS: CSR 0x340 holds 0x00F0, rs1=x5 with value 0x0F00, rd=x7 -> EXEC writes 0x0FF0; RD_WE=1, RD_ADDR=7, RD_WDATA=0x00F0; READY low for exactly 1 cycle.
- CSRRCI: addr 0x300, zimm=0 -> CSR_LD=0, RD_WE=1. Same with CSRRW to 0xC00 -> ILLEGAL=1, no write.
- Trap: EXC_PC=0x8000_0100, cause=2, PRIVILEGE=3, mstatus=0x8, MTVEC=0x8000_0000 -> writes mepc, mcause, then mstatus=0x1880 on three consecutive cycles; REDIRECT=1 with PC 0x8000_0000 on the third.
- Vectored interrupt: MTVEC=0x8000_0001, cause=0x8000_0000_0000_0007 -> REDIRECT_PC=0x8000_001C.
- Priority/MRET: EXC_REQ, MRET and VALID_IN all high in IDLE -> trap only. MRET with mstatus=0x1880, mepc=0x8000_0102 -> mstatus=0x0088, REDIRECT_PC=0x8000_0100 one cycle later.
